// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master drives operands and accepts results; the slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B - BIN, one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flip-flop.
// Sequence: IDLE (accept operands) -> RUN (WIDTH bit steps) -> DONE (present result).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_alive;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_amsb;
  logic             r_bmsb;
  logic [CW-1:0]    r_cnt;

  logic             w_in_ready;
  logic             w_load;
  logic             w_step;
  logic [1:0]       w_fs;

  // Full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fs_cell(input logic ai, input logic bi, input logic bri);
    logic d;
    logic bo;
    d  = ai ^ bi ^ bri;
    bo = (~ai & bi) | (~(ai ^ bi) & bri);
    return {bo, d};
  endfunction

  assign w_fs       = fs_cell(r_a[0], r_b[0], r_br);
  // in_ready stays low until the first edge after reset release.
  assign w_in_ready = r_alive && (r_state == IDLE);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == DONE);
  assign bus.diff      = r_diff;
  assign bus.bout      = r_br;
  assign bus.ovf       = (r_amsb != r_bmsb) && (r_diff[WIDTH-1] != r_amsb);

  // State register and out-of-reset flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_alive <= 1'b1;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_in_ready && bus.in_valid) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST) w_state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand shift registers, borrow flop, bit counter and result shift-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_diff <= '0;
      r_br   <= 1'b0;
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_a    <= bus.a;
      r_b    <= bus.b;
      r_br   <= bus.bin;
      r_amsb <= bus.a[WIDTH-1];
      r_bmsb <= bus.b[WIDTH-1];
      r_cnt  <= '0;
    end else if (w_step) begin
      r_diff <= {w_fs[0], r_diff[WIDTH-1:1]};
      r_br   <= w_fs[1];
      r_a    <= {1'b0, r_a[WIDTH-1:1]};
      r_b    <= {1'b0, r_b[WIDTH-1:1]};
      r_cnt  <= r_cnt + CW'(1);
    end
  end

endmodule
